gcd_stein_engine: RTL and testbench
===================================

// Module: gcd_stein_engine
// PURPOSE
//  Parametrised binary (Stein) GCD engine. Next generation of the team's 8-bit subtractive GCD unit.
//  Generic WIDTH; valid/ready on both input and output, so downstream can apply backpressure.
//  Carries a sideband tag through the calculation. Reports zero-operand, coprime and cycle-count status.
//  Used as a shared arithmetic slave behind the number-theory request arbiter.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
//  TAG_W   4   width of opaque request tag passed input->output
//  CW      $clog2(2*WIDTH+1)   width of out_cycles (localparam, not overridable)
// PORTS
//  clk          in   1        rising-edge clock; the block has one clock
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        request valid
//  in_ready     out  1        engine can accept; = (state==IDLE), combinational from state
//  in_a         in   WIDTH    operand A
//  in_b         in   WIDTH    operand B
//  in_tag       in   TAG_W    request tag
//  out_valid    out  1        result valid, held until out_ready
//  out_ready    in   1        downstream accepts result
//  out_gcd      out  WIDTH    gcd(A,B); gcd(0,0)=0
//  out_tag      out  TAG_W    tag of this result
//  out_zero     out  1        A==0 or B==0 at accept
//  out_coprime  out  1        out_gcd==1
//  out_cycles   out  CW       REDUCE cycles spent (0 for zero-operand requests)
//  busy         out  1        state!=IDLE
// BEHAVIOUR
//  Reset: state=IDLE. out_valid, out_gcd, out_tag, out_zero, out_coprime and out_cycles are all 0.
//    Internal x, y, k and cycle counter are all 0. in_ready=1 and busy=0 during and after reset.
//  FSM states:
//    IDLE: a request is accepted on in_valid&&in_ready. Accept latches a, b and tag.
//      If a==0 or b==0: out_gcd=a|b, out_zero=1, out_cycles=0, go to OUT.
//        Result valid on the next cycle.
//      Otherwise: x=a, y=b, k=0, cnt=0, go to REDUCE.
//    REDUCE: one step per cycle, cnt++. Checks are made in this priority order:
//      1. x==y: out_gcd=x<<k, go to OUT.
//      2. x and y both even: x>>=1, y>>=1, k++.
//      3. Only x even: x>>=1.
//      4. Only y even: y>>=1.
//      5. Both odd, x>y: x=(x-y)>>1.
//      6. Both odd, x<y: y=(y-x)>>1.
//      On exit: out_cycles=cnt including the terminating cycle.
//        out_coprime=(gcd==1). out_zero=0.
//    OUT: out_valid=1. All out_* fields are stable until out_ready.
//      out_valid&&out_ready -> IDLE, out_valid=0 next cycle.
//      No new accept is made in OUT (in_ready=0), so there is no same-cycle bypass.
//  Width rules:
//    x and y are WIDTH bits. The subtraction is unsigned with the larger operand minus the smaller, so it never wraps.
//    k is $clog2(WIDTH+1) bits. x<<k never exceeds the original min(a,b), so there is no overflow.
//  Latency bound: REDUCE exits after at most 2*WIDTH cycles.
//    Each step removes at least one bit from x+y. cnt never saturates within CW bits.
//  Throughput: one request per (REDUCE cycles + 2) cycles when out_ready is held high.
//  in_valid while busy: ignored and not latched. The requester must hold it until in_ready.
//  Backpressure: the engine may sit in OUT indefinitely. The result is not overwritten.
//  rst asserted mid-operation: the in-flight request is discarded.
//    No out_valid pulse for it. The engine returns to reset values immediately.
//  out_* registers are updated only on the transition into OUT. Between results they hold the last value.
// STRUCTURE
//  Shared package gcd_pkg holds:
//    state enum gcd_state_t {IDLE, REDUCE, OUT}
//    function cnt_width(WIDTH) used for CW
//    step-kind constants used by the bench coverage.
//  Sub-module gcd_stein_step (combinational):
//    Inputs x, y, k. Outputs next x, y, k and an equal flag.
//    Implements priority rules 1-6 above. The FSM, counter and output registers stay in gcd_stein_engine.
// TESTING
//  T1 (48,18), tag=3: out_gcd=6, out_cycles=6, out_tag=3, out_coprime=0, out_zero=0.
//  T2 (17,5): out_gcd=1, out_coprime=1, out_cycles=5.
//  T3 zero operands:
//    (0,37): out_gcd=37, out_zero=1, out_cycles=0, out_valid one cycle after accept.
//    (0,0): out_gcd=0, out_zero=1.
//  T4 WIDTH=8 extremes:
//    (255,255): out_gcd=255, out_cycles=1.
//    (128,1): out_gcd=1, out_cycles=8.
//    Random pairs vs reference model, cycles<=16.
//  T5 backpressure:
//    Hold out_ready=0 for 20 cycles. out_valid and all fields stay stable, in_ready=0, a second in_valid is not taken.
//    Release out_ready: the second request is accepted in the cycle after the OUT->IDLE transition.
//  T6 reset mid-REDUCE during (48,18):
//    Assert rst at cycle 3. All outputs go to 0 immediately, in_ready=1, no stale out_valid.
//    A subsequent (9,6) returns 3.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the binary (Stein) GCD engine: FSM states, counter sizing
// and the step-kind codes used to classify REDUCE steps.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        OUT    = 2'd2
    } gcd_state_t;

    // Enough bits to count 2*width REDUCE cycles without saturating.
    function automatic int cnt_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

    localparam int STEP_EQUAL     = 0;
    localparam int STEP_BOTH_EVEN = 1;
    localparam int STEP_X_EVEN    = 2;
    localparam int STEP_Y_EVEN    = 3;
    localparam int STEP_X_GT      = 4;
    localparam int STEP_Y_GT      = 5;
    localparam int NUM_STEP_KINDS = 6;

endpackage

// File: rtl/gcd_stein_step.sv
// Combinational single step of the Stein reduction: given (x, y, k) produce the
// next (x, y, k) and flag termination when x equals y.
module gcd_stein_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] x_next,
    output logic [WIDTH-1:0] y_next,
    output logic [KW-1:0]    k_next,
    output logic             equal
);

    logic [WIDTH-1:0] diff;

    always_comb begin
        x_next = x;
        y_next = y;
        k_next = k;
        equal  = (x == y);
        // Larger minus smaller, so the subtraction never wraps.
        diff   = (x > y) ? (x - y) : (y - x);

        if (!equal) begin
            if (!x[0] && !y[0]) begin
                x_next = x >> 1;
                y_next = y >> 1;
                k_next = k + KW'(1);
            end else if (!x[0]) begin
                x_next = x >> 1;
            end else if (!y[0]) begin
                y_next = y >> 1;
            end else if (x > y) begin
                x_next = diff >> 1;
            end else begin
                y_next = diff >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_stein_engine.sv
// Binary GCD engine with valid/ready handshakes, a pass-through tag and
// zero-operand / coprime / cycle-count status on the result.
module gcd_stein_engine
    import gcd_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int TAG_W = 4,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_coprime,
    output logic [CW-1:0]    out_cycles,
    output logic             busy
);

    localparam int KW = $clog2(WIDTH + 1);

    gcd_state_t       state;
    gcd_state_t       state_next;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [KW-1:0]    k;
    logic [CW-1:0]    cnt;
    logic [TAG_W-1:0] tag;

    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] y_next;
    logic [KW-1:0]    k_next;
    logic             equal;
    logic             zero_op;
    logic [WIDTH-1:0] zero_gcd;
    logic [WIDTH-1:0] gcd_val;
    logic [CW-1:0]    cnt_inc;

    gcd_stein_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .x      (x),
        .y      (y),
        .k      (k),
        .x_next (x_next),
        .y_next (y_next),
        .k_next (k_next),
        .equal  (equal)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign zero_op   = (in_a == '0) || (in_b == '0);
    assign zero_gcd  = in_a | in_b;
    // The common power of two is restored only at the end; it cannot overflow
    // because the result never exceeds the smaller original operand.
    assign gcd_val   = x << k;
    assign cnt_inc   = cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = zero_op ? OUT : REDUCE;
            REDUCE:  if (equal) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result fields change only on entry to OUT so they hold across backpressure
    // and between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            k           <= '0;
            cnt         <= '0;
            tag         <= '0;
            out_gcd     <= '0;
            out_tag     <= '0;
            out_zero    <= 1'b0;
            out_coprime <= 1'b0;
            out_cycles  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tag <= in_tag;
                        if (zero_op) begin
                            out_gcd     <= zero_gcd;
                            out_tag     <= in_tag;
                            out_zero    <= 1'b1;
                            out_coprime <= (zero_gcd == WIDTH'(1));
                            out_cycles  <= '0;
                        end else begin
                            x   <= in_a;
                            y   <= in_b;
                            k   <= '0;
                            cnt <= '0;
                        end
                    end
                end
                REDUCE: begin
                    cnt <= cnt_inc;
                    if (equal) begin
                        out_gcd     <= gcd_val;
                        out_tag     <= tag;
                        out_zero    <= 1'b0;
                        out_coprime <= (gcd_val == WIDTH'(1));
                        out_cycles  <= cnt_inc;
                    end else begin
                        x <= x_next;
                        y <= y_next;
                        k <= k_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stein_engine.sv
// Self-checking bench for gcd_stein_engine: directed cases, random pairs against
// a behavioural model, backpressure, mid-operation reset and back-to-back flow.
module tb_gcd_stein_engine;
    import gcd_pkg::*;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int CW    = cnt_width(WIDTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_coprime;
    logic [CW-1:0]    out_cycles;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int kind_hits [NUM_STEP_KINDS];

    gcd_stein_engine #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_gcd     (out_gcd),
        .out_tag     (out_tag),
        .out_zero    (out_zero),
        .out_coprime (out_coprime),
        .out_cycles  (out_cycles),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference gcd by Euclid's remainder algorithm.
    function automatic int ref_gcd(input int a, input int b);
        int p = a;
        int q = b;
        int t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Number of REDUCE steps the Stein rules take, counting the terminating one.
    function automatic int ref_cycles(input int a, input int b);
        int p = a;
        int q = b;
        int n = 0;
        if (a == 0 || b == 0) return 0;
        while (n < 1000) begin
            n++;
            if (p == q) begin
                kind_hits[STEP_EQUAL]++;
                return n;
            end else if (p % 2 == 0 && q % 2 == 0) begin
                p = p / 2; q = q / 2; kind_hits[STEP_BOTH_EVEN]++;
            end else if (p % 2 == 0) begin
                p = p / 2; kind_hits[STEP_X_EVEN]++;
            end else if (q % 2 == 0) begin
                q = q / 2; kind_hits[STEP_Y_EVEN]++;
            end else if (p > q) begin
                p = (p - q) / 2; kind_hits[STEP_X_GT]++;
            end else begin
                q = (q - p) / 2; kind_hits[STEP_Y_GT]++;
            end
        end
        return n;
    endfunction

    // Presents one request, waits for acceptance, then for out_valid.
    // lat counts negedges from the accepting edge until out_valid is seen.
    task automatic run_req(input int a, input int b, input int t,
                           output logic ok, output int lat);
        @(negedge clk);
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        in_tag   = TAG_W'(t);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        ok  = 1'b0;
        lat = 0;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout a=%0d b=%0d in_ready=%0b required 1", a, b, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_gcd, out_tag, out_zero, out_coprime, out_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %0h required 0",
                     {out_valid, out_gcd, out_tag, out_zero, out_coprime, out_cycles});
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready in_ready=%0b busy=%0b required 1/0", in_ready, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset in_ready=%0b busy=%0b out_valid=%0b required 1/0/0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_directed;
        int   da [6] = '{48, 17, 0, 0, 255, 128};
        int   db [6] = '{18, 5, 37, 0, 255, 1};
        int   dg [6] = '{6, 1, 37, 0, 255, 1};
        int   dc [6] = '{6, 5, 0, 0, 1, 8};
        int   dz [6] = '{0, 0, 1, 1, 0, 0};
        logic ok;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            run_req(da[i], db[i], i + 3, ok, lat);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL dir_timeout case=%0d no out_valid required 1", i);
            end
            checks++;
            if (out_gcd !== WIDTH'(dg[i]) || out_cycles !== CW'(dc[i]) ||
                out_tag !== TAG_W'(i + 3) || out_zero !== dz[i][0] ||
                out_coprime !== (dg[i] == 1)) begin
                errors++;
                $display("FAIL dir_fields case=%0d got gcd=%0d cyc=%0d tag=%0d z=%0b c=%0b required gcd=%0d cyc=%0d tag=%0d z=%0b c=%0b",
                         i, out_gcd, out_cycles, out_tag, out_zero, out_coprime,
                         dg[i], dc[i], i + 3, dz[i][0], dg[i] == 1);
            end
            checks++;
            if (lat !== ((dz[i] != 0) ? 1 : dc[i] + 1)) begin
                errors++;
                $display("FAIL dir_latency case=%0d got %0d required %0d",
                         i, lat, (dz[i] != 0) ? 1 : dc[i] + 1);
            end
            release_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir_release case=%0d out_valid=%0b in_ready=%0b required 0/1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random;
        logic ok;
        int   lat, a, b, t, eg, ec;
        for (int i = 0; i < 40; i++) begin
            a  = (i % 10 == 9) ? 0 : int'($urandom_range(255, 1));
            b  = int'($urandom_range(255, 1));
            t  = int'($urandom_range(15, 0));
            eg = ref_gcd(a, b);
            ec = ref_cycles(a, b);
            run_req(a, b, t, ok, lat);
            checks++;
            if (!ok || out_gcd !== WIDTH'(eg) || out_tag !== TAG_W'(t) ||
                out_cycles !== CW'(ec) || out_zero !== (a == 0) ||
                out_coprime !== (eg == 1)) begin
                errors++;
                $display("FAIL rand (%0d,%0d) ok=%0b got gcd=%0d cyc=%0d tag=%0d z=%0b c=%0b required gcd=%0d cyc=%0d tag=%0d z=%0b c=%0b",
                         a, b, ok, out_gcd, out_cycles, out_tag, out_zero, out_coprime,
                         eg, ec, t, a == 0, eg == 1);
            end
            checks++;
            if (int'(out_cycles) > 2 * WIDTH) begin
                errors++;
                $display("FAIL rand_bound (%0d,%0d) cycles=%0d required <=%0d",
                         a, b, out_cycles, 2 * WIDTH);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure;
        logic ok;
        int   lat;
        int   bad = 0;
        run_req(48, 18, 1, ok, lat);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_first no out_valid required 1");
        end
        in_a     = 8'd9;
        in_b     = 8'd6;
        in_tag   = 4'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_gcd !== 8'd6 || out_tag !== 4'd1 ||
                out_cycles !== 5'd6 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold unstable_cycles=%0d required 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_gcd !== 8'd6) begin
            errors++;
            $display("FAIL bp_idle in_ready=%0b out_valid=%0b gcd=%0d required 1/0/6",
                     in_ready, out_valid, out_gcd);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept busy=%0b required 1", busy);
        end
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok || out_gcd !== 8'd3 || out_tag !== 4'd2 || out_cycles !== 5'd3) begin
            errors++;
            $display("FAIL bp_second ok=%0b gcd=%0d tag=%0d cyc=%0d required 1/3/2/3",
                     ok, out_gcd, out_tag, out_cycles);
        end
        release_out();
    endtask

    task automatic test_reset_mid;
        logic ok;
        int   lat;
        int   stale = 0;
        @(negedge clk);
        in_a     = 8'd48;
        in_b     = 8'd18;
        in_tag   = 4'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_gcd, out_tag, out_zero, out_coprime, out_cycles} !== '0 ||
            in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got %0h in_ready=%0b busy=%0b required 0/1/0",
                     {out_valid, out_gcd, out_tag, out_zero, out_coprime, out_cycles},
                     in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midrst_stale out_valid_cycles=%0d required 0", stale);
        end
        run_req(9, 6, 6, ok, lat);
        checks++;
        if (!ok || out_gcd !== 8'd3 || out_tag !== 4'd6) begin
            errors++;
            $display("FAIL midrst_after ok=%0b gcd=%0d tag=%0d required 1/3/6",
                     ok, out_gcd, out_tag);
        end
        release_out();
    endtask

    task automatic test_back_to_back;
        int   ra [4];
        int   rb [4];
        int   rc [4];
        int   idx = 0;
        int   got = 0;
        int   last = -1;
        logic acc;
        for (int i = 0; i < 4; i++) begin
            ra[i] = (i == 2) ? 0 : int'($urandom_range(255, 1));
            rb[i] = int'($urandom_range(255, 1));
            rc[i] = ref_cycles(ra[i], rb[i]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_a     = WIDTH'(ra[0]);
        in_b     = WIDTH'(rb[0]);
        in_tag   = 4'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 400 && got < 4; c++) begin
            if (out_valid) begin
                checks++;
                if (out_gcd !== WIDTH'(ref_gcd(ra[got], rb[got])) || out_tag !== TAG_W'(got)) begin
                    errors++;
                    $display("FAIL b2b_result n=%0d got gcd=%0d tag=%0d required gcd=%0d tag=%0d",
                             got, out_gcd, out_tag, ref_gcd(ra[got], rb[got]), got);
                end
                got++;
            end
            acc = in_ready && in_valid;
            @(posedge clk);
            if (acc) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != rc[idx - 1] + 2) begin
                        errors++;
                        $display("FAIL b2b_interval n=%0d got %0d required %0d",
                                 idx, c - last, rc[idx - 1] + 2);
                    end
                end
                last = c;
                idx++;
                #1;
                if (idx < 4) begin
                    in_a   = WIDTH'(ra[idx]);
                    in_b   = WIDTH'(rb[idx]);
                    in_tag = TAG_W'(idx);
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d required 4", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_STEP_KINDS; i++) kind_hits[i] = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("step coverage eq=%0d both_even=%0d x_even=%0d y_even=%0d x_gt=%0d y_gt=%0d",
                 kind_hits[STEP_EQUAL], kind_hits[STEP_BOTH_EVEN], kind_hits[STEP_X_EVEN],
                 kind_hits[STEP_Y_EVEN], kind_hits[STEP_X_GT], kind_hits[STEP_Y_GT]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
